// File: rtl/fifomult_par.sv
// ============================================================================
// fifomult_par : parity-checked operand FIFO feeding a signed pair multiplier
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fifomult_par #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_in_parity,
  input  logic                  data_in_valid,
  input  logic                  data_out_ready,
  output logic                  busy_out,
  output logic [2*DATA_W-1:0]   data_out,
  output logic                  data_out_parity,
  output logic                  data_out_valid,
  output logic                  data_in_parity_error,
  output logic [ERRCNT_W-1:0]   err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Each entry carries the operand plus a bad-parity tag in the MSB.
  logic [DATA_W:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic                  wr_en;
  logic                  pop;
  logic                  out_free;
  logic [PTR_W-1:0]      rd_ptr_b;
  logic [DATA_W:0]       entry_a;
  logic [DATA_W:0]       entry_b;
  logic                  pair_bad;
  logic [2*DATA_W-1:0]   a_ext;
  logic [2*DATA_W-1:0]   b_ext;
  logic [2*DATA_W-1:0]   product;
  logic [2*DATA_W-1:0]   result;
  logic [PTR_W:0]        count_nxt;

  assign busy_out = (count == (PTR_W+1)'(DEPTH));
  assign wr_en    = data_in_valid && !busy_out;
  assign out_free = !data_out_valid || data_out_ready;
  assign pop      = (count >= (PTR_W+1)'(2)) && out_free;

  assign rd_ptr_b = rd_ptr + 1'b1;
  assign entry_a  = fifo_mem[rd_ptr];
  assign entry_b  = fifo_mem[rd_ptr_b];
  assign pair_bad = entry_a[DATA_W] || entry_b[DATA_W];

  // Sign-extend to full width so the low 2*DATA_W bits are the exact product.
  assign a_ext   = {{DATA_W{entry_a[DATA_W-1]}}, entry_a[DATA_W-1:0]};
  assign b_ext   = {{DATA_W{entry_b[DATA_W-1]}}, entry_b[DATA_W-1:0]};
  assign product = a_ext * b_ext;
  assign result  = pair_bad ? '0 : product;

  always_comb begin
    count_nxt = count;
    if (wr_en) count_nxt = count_nxt + (PTR_W+1)'(1);
    if (pop)   count_nxt = count_nxt - (PTR_W+1)'(2);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      fifo_mem[wr_ptr] <= {(^data_in) != data_in_parity, data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out             <= '0;
      data_out_parity      <= 1'b0;
      data_out_valid       <= 1'b0;
      data_in_parity_error <= 1'b0;
      err_cnt              <= '0;
    end else if (pop) begin
      data_out             <= result;
      data_out_parity      <= ^result;
      data_out_valid       <= 1'b1;
      data_in_parity_error <= pair_bad;
      if (pair_bad && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
